// File: rtl/router_input_buffer_if.sv
// Flit link between a credit-based sender, the input buffer and the crossbar.
// The buffer side takes the slave modport; the sender/crossbar/bench side takes master.
interface router_input_buffer_if #(
  parameter int FLIT_W = 20
);
  logic [FLIT_W-1:0] in;
  logic              vi;
  logic              deq;
  logic [FLIT_W-1:0] o;
  logic              vo;
  logic [4:0]        req;
  logic              co;
  logic              err;

  modport master (
    output in, vi, deq,
    input  o, vo, req, co, err
  );

  modport slave (
    input  in, vi, deq,
    output o, vo, req, co, err
  );
endinterface

// File: rtl/router_input_buffer.sv
// Router input port: credit-returning flit FIFO with XY route computation
// for the head flit, a registered credit pulse and a sticky overflow flag.
module router_input_buffer #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 20
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [3:0]            position,
  router_input_buffer_if.slave  link
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              co_q;
  logic              err_q;

  logic              vo;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              overflow;

  assign vo   = (count != '0);
  assign full = (count == FULL_COUNT);
  assign pop  = link.deq & vo;

  // A full buffer can still take a flit when the head leaves in the same cycle;
  // an empty buffer never bypasses, so a simultaneous deq there is ignored.
  assign wr_en    = link.vi & (~full | pop);
  assign overflow = link.vi & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= link.in;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      co_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      co_q <= pop;
      if (overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  logic [3:0] dest;
  logic [1:0] dx;
  logic [1:0] dy;
  logic [1:0] own_x;
  logic [1:0] own_y;
  logic [4:0] req_c;

  assign dest  = link.o[FLIT_W-1 -: 4];
  assign dx    = dest[1:0];
  assign dy    = dest[3:2];
  assign own_x = position[1:0];
  assign own_y = position[3:2];

  // Dimension-order routing: resolve X first, then Y, then eject locally.
  always_comb begin
    req_c = '0;
    if (vo) begin
      if (dx > own_x) begin
        req_c[0] = 1'b1;
      end else if (dx < own_x) begin
        req_c[1] = 1'b1;
      end else if (dy > own_y) begin
        req_c[2] = 1'b1;
      end else if (dy < own_y) begin
        req_c[3] = 1'b1;
      end else begin
        req_c[4] = 1'b1;
      end
    end
  end

  assign link.o   = mem[rd_ptr];
  assign link.vo  = vo;
  assign link.req = req_c;
  assign link.co  = co_q;
  assign link.err = err_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Scoreboard bench for router_input_buffer: expected flits are queued as they
// are written and compared as the crossbar side pops them.
module tb_router_input_buffer;

  localparam int DEPTH  = 4;
  localparam int FLIT_W = 20;

  logic       clk;
  logic       RST;
  logic [3:0] position;

  router_input_buffer_if #(.FLIT_W(FLIT_W)) link ();

  router_input_buffer #(
    .DEPTH (DEPTH),
    .FLIT_W(FLIT_W)
  ) dut (
    .clk     (clk),
    .RST     (RST),
    .position(position),
    .link    (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount;
  int errorCount;
  int creditCount;

  logic [FLIT_W-1:0] expQueue [$];
  int                mdlCount;
  logic              mdlErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One-hot XY route of a destination seen from node pos.
  function automatic logic [4:0] routeOf(input logic [3:0] dest, input logic [3:0] pos);
    int dxi, dyi, xi, yi;
    dxi = int'(dest[1:0]);
    dyi = int'(dest[3:2]);
    xi  = int'(pos[1:0]);
    yi  = int'(pos[3:2]);
    if (dxi != xi) return (dxi > xi) ? 5'b00001 : 5'b00010;
    if (dyi != yi) return (dyi > yi) ? 5'b00100 : 5'b01000;
    return 5'b10000;
  endfunction

  // Drives one cycle from just after a rising edge, checks the popped flit
  // before the edge and the registered outputs after it.
  task automatic applyStimulus(input logic viV, input logic [FLIT_W-1:0] flitV,
                               input logic deqV);
    logic popExp;
    logic wrExp;
    link.vi  = viV;
    link.in  = flitV;
    link.deq = deqV;
    popExp = deqV && (mdlCount != 0);
    wrExp  = viV && ((mdlCount < DEPTH) || popExp);
    if (popExp) begin
      checkOutput("pop_vo", 32'(link.vo), 32'd1);
      checkOutput("pop_data", 32'(link.o), 32'(expQueue.pop_front()));
    end
    if (wrExp) expQueue.push_back(flitV);
    else if (viV) mdlErr = 1'b1;
    if (wrExp && !popExp) mdlCount++;
    else if (popExp && !wrExp) mdlCount--;
    @(posedge clk);
    #1;
    link.vi  = 1'b0;
    link.deq = 1'b0;
    checkOutput("co", 32'(link.co), 32'(popExp));
    if (link.co === 1'b1) creditCount++;
    checkOutput("err", 32'(link.err), 32'(mdlErr));
    checkOutput("vo", 32'(link.vo), 32'(mdlCount != 0));
    if (mdlCount != 0) begin
      checkOutput("head", 32'(link.o), 32'(expQueue[0]));
      checkOutput("req", 32'(link.req), 32'(routeOf(expQueue[0][FLIT_W-1 -: 4], position)));
    end else begin
      checkOutput("req_idle", 32'(link.req), 32'd0);
    end
  endtask

  task automatic resetModel();
    expQueue.delete();
    mdlCount = 0;
    mdlErr   = 1'b0;
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int creditStart;
    logic [3:0] dests [4];
    checkCount  = 0;
    errorCount  = 0;
    creditCount = 0;
    position    = 4'h5;
    link.vi     = 1'b0;
    link.deq    = 1'b0;
    link.in     = '0;
    RST         = 1'b1;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_vo", 32'(link.vo), 32'd0);
    checkOutput("rst_co", 32'(link.co), 32'd0);
    checkOutput("rst_err", 32'(link.err), 32'd0);
    checkOutput("rst_req", 32'(link.req), 32'd0);
    RST = 1'b0;

    // Async reset mid-cycle with two flits buffered
    applyStimulus(1'b1, 20'h7_0001, 1'b0);
    applyStimulus(1'b1, 20'h4_0002, 1'b0);
    checkOutput("pre_rst_vo", 32'(link.vo), 32'd1);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("async_vo", 32'(link.vo), 32'd0);
    checkOutput("async_co", 32'(link.co), 32'd0);
    checkOutput("async_err", 32'(link.err), 32'd0);
    checkOutput("async_req", 32'(link.req), 32'd0);
    resetModel();
    @(posedge clk);
    #1;
    RST = 1'b0;
    repeat (2) applyStimulus(1'b0, '0, 1'b0);

    // Fill/drain from node (1,1): east, west, north, local
    position = 4'h5;
    dests[0] = 4'h7; dests[1] = 4'h4; dests[2] = 4'hD; dests[3] = 4'h5;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, {dests[i], 16'(16'h1000 + i)}, 1'b0);
    checkOutput("fill_req_east", 32'(link.req), 32'h01);
    creditStart = creditCount;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_credits", 32'(creditCount - creditStart), 32'd4);

    // Full plus simultaneous write and pop
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 20'(20'h3_2000 + i), 1'b0);
    applyStimulus(1'b1, 20'hABCDE, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);

    // Overflow: the extra flit is dropped and err sticks
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 20'(20'hC_4000 + i), 1'b0);
    creditStart = creditCount;
    applyStimulus(1'b1, 20'h12345, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ovf_credits", 32'(creditCount - creditStart), 32'd4);
    checkOutput("ovf_sticky", 32'(link.err), 32'd1);
    pulseReset();
    checkOutput("err_cleared", 32'(link.err), 32'd0);

    // Empty corners: lone deq, then write and deq together
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 20'h5_5555, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

    // Stream across pointer wrap with alternating deq and varied positions
    creditStart = creditCount;
    for (int i = 0; i < 20; i++) begin
      position = 4'($urandom_range(0, 15));
      if ((i % 2) == 0) applyStimulus(1'b1, 20'($urandom), 1'b0);
      else applyStimulus(1'b0, '0, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("wrap_credits", 32'(creditCount - creditStart), 32'd10);
    checkOutput("wrap_empty", 32'(expQueue.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
